// File: rtl/regfile_access_ctrl_if.sv
// Host-side command and response channels for regfile_access_ctrl.
// Master is the host; slave is the controller.
interface regfile_access_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_last;

  modport master (
    output req_valid, req_write, req_addr,
    output req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: single-beat writes and wrapping read bursts.
// Every output is registered from the next-state decode.
module regfile_access_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  regfile_access_ctrl_if.slave host,
  output logic              err,
  output logic              busy,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Address,
  output logic [WIDTH-1:0]  WrData,
  input  logic [WIDTH-1:0]  RdData
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LP_ONE =
    ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_len;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_data;
  logic              r_rsp_last;
  logic              r_err;
  logic              r_busy;
  logic              r_wr_en;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_address;
  logic [WIDTH-1:0]  r_wr_data;

  state_t            w_nstate;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_len;
  logic [WIDTH-1:0]  w_wdata;
  logic              w_rsp_valid;
  logic [WIDTH-1:0]  w_rsp_data;
  logic              w_rsp_last;
  logic              w_err;
  logic [ADDR_W-1:0] w_address;
  logic [WIDTH-1:0]  w_wr_data;
  logic              w_accept;
  logic              w_bad;

  assign w_accept = r_req_ready && host.req_valid;
  assign w_bad    = {1'b0, host.req_addr} >= LP_DEPTH;

  // Next state, latched command and next value of every output.
  always_comb begin
    w_nstate    = r_state;
    w_addr      = r_addr;
    w_len       = r_len;
    w_wdata     = r_wdata;
    w_rsp_valid = r_rsp_valid;
    w_rsp_data  = r_rsp_data;
    w_rsp_last  = r_rsp_last;
    w_err       = 1'b0;
    w_address   = r_address;
    w_wr_data   = r_wr_data;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_bad) begin
            w_err = 1'b1;
          end else begin
            w_addr   = host.req_addr;
            w_len    = host.req_len;
            w_wdata  = host.req_wdata;
            w_nstate = host.req_write ? WRITE
                                      : RD_ISSUE;
          end
        end
      end
      WRITE: w_nstate = IDLE;
      RD_ISSUE: w_nstate = RD_WAIT;
      RD_WAIT: begin
        w_rsp_data  = RdData;
        w_rsp_valid = 1'b1;
        w_rsp_last  = (r_len == '0);
        w_nstate    = RD_RESP;
      end
      RD_RESP: begin
        if (host.rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_rsp_last  = 1'b0;
          if (r_len == '0) begin
            w_nstate = IDLE;
          end else begin
            w_len    = r_len - LP_ONE;
            w_addr   = (r_addr == LP_LAST) ? '0
                     : r_addr + LP_ONE;
            w_nstate = RD_ISSUE;
          end
        end
      end
      default: w_nstate = IDLE;
    endcase
    if (w_nstate == WRITE ||
        w_nstate == RD_ISSUE) begin
      w_address = w_addr;
    end
    if (w_nstate == WRITE) begin
      w_wr_data = w_wdata;
    end
  end

  // State, command latches and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_address   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_nstate;
      r_addr      <= w_addr;
      r_len       <= w_len;
      r_wdata     <= w_wdata;
      r_req_ready <= (w_nstate == IDLE);
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_last  <= w_rsp_last;
      r_err       <= w_err;
      r_busy      <= (w_nstate != IDLE);
      r_wr_en     <= (w_nstate == WRITE);
      r_rd_en     <= (w_nstate == RD_ISSUE);
      r_address   <= w_address;
      r_wr_data   <= w_wr_data;
    end
  end

  assign host.req_ready = r_req_ready;
  assign host.rsp_valid = r_rsp_valid;
  assign host.rsp_data  = r_rsp_data;
  assign host.rsp_last  = r_rsp_last;
  assign err            = r_err;
  assign busy           = r_busy;
  assign WrEn           = r_wr_en;
  assign RdEn           = r_rd_en;
  assign Address        = r_address;
  assign WrData         = r_wr_data;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl with DEPTH=7 so address 7 is rejected
// and bursts wrap at a non-power-of-two boundary.
module tb_regfile_access_ctrl;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 7;
  localparam int ADDR_W = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              err;
  logic              busy;
  logic              WrEn;
  logic              RdEn;
  logic [ADDR_W-1:0] Address;
  logic [WIDTH-1:0]  WrData;
  logic [WIDTH-1:0]  RdData = '0;

  regfile_access_ctrl_if #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W)
  ) bus ();

  regfile_access_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) u_dut (
    .CLK(CLK), .RST(RST), .host(bus),
    .err(err), .busy(busy),
    .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData),
    .RdData(RdData)
  );

  always #5 CLK = ~CLK;

  // Register file the controller talks to.
  logic [WIDTH-1:0] rf_mem [8];
  always @(posedge CLK) begin
    if (WrEn) rf_mem[Address] <= WrData;
    if (RdEn) RdData <= rf_mem[Address];
  end

  // Reference model state and scoreboard queues.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  d;
  } wr_t;
  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             l;
  } rsp_t;

  logic [WIDTH-1:0]  ref_mem [8];
  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_ra[$];
  rsp_t              exp_rsp[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rr_pct   = 100;
  bit rr_low   = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               nm, got, exp);
    end
  endtask

  // Host response-side backpressure, changed just after each edge.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      bus.rsp_ready = !rr_low &&
        ($urandom_range(0, 99) < rr_pct);
    end
  end

  // Monitor: strobes, response beats and backpressure stability.
  initial begin
    bit               pv = 1'b0;
    bit               pr = 1'b0;
    logic [WIDTH-1:0] pd = '0;
    bit               pl = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("wr_rd_overlap", {31'd0, WrEn && RdEn}, 0);
        if (WrEn) begin
          chk("wr_expected",
              {31'd0, exp_wr.size() > 0}, 1);
          if (exp_wr.size() > 0) begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", {29'd0, Address}, {29'd0, e.a});
            chk("wr_data", {16'd0, WrData}, {16'd0, e.d});
          end
        end
        if (RdEn) begin
          chk("rd_expected",
              {31'd0, exp_ra.size() > 0}, 1);
          chk("rd_while_valid",
              {31'd0, bus.rsp_valid}, 0);
          if (exp_ra.size() > 0) begin
            logic [ADDR_W-1:0] ea;
            ea = exp_ra.pop_front();
            chk("rd_addr", {29'd0, Address}, {29'd0, ea});
          end
        end
        if (pv && !pr) begin
          chk("bp_valid", {31'd0, bus.rsp_valid}, 1);
          chk("bp_data", {16'd0, bus.rsp_data},
              {16'd0, pd});
          chk("bp_last", {31'd0, bus.rsp_last},
              {31'd0, pl});
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          chk("rsp_expected",
              {31'd0, exp_rsp.size() > 0}, 1);
          if (exp_rsp.size() > 0) begin
            rsp_t e;
            e = exp_rsp.pop_front();
            chk("rsp_data", {16'd0, bus.rsp_data},
                {16'd0, e.d});
            chk("rsp_last", {31'd0, bus.rsp_last},
                {31'd0, e.l});
          end
        end
        pv = bus.rsp_valid;
        pr = bus.rsp_ready;
        pd = bus.rsp_data;
        pl = bus.rsp_last;
      end else begin
        pv = 1'b0;
      end
    end
  end

  // Issue one command, update the model and check accept-relative timing.
  task automatic do_cmd(input bit w,
                        input logic [ADDR_W-1:0] a,
                        input logic [ADDR_W-1:0] l,
                        input logic [WIDTH-1:0] d);
    int  n;
    bit  bad;
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_len   = l;
    bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      chk("req_ready_timeout", 1, 0);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    bad = (int'(a) >= DEPTH);
    if (!bad) begin
      if (w) begin
        ref_mem[a] = d;
        exp_wr.push_back('{a: a, d: d});
      end else begin
        for (int i = 0; i <= int'(l); i++) begin
          int ra;
          rsp_t r;
          ra = (int'(a) + i) % DEPTH;
          exp_ra.push_back(ADDR_W'(ra));
          r.d = ref_mem[ra];
          r.l = (i == int'(l));
          exp_rsp.push_back(r);
        end
      end
    end
    @(negedge CLK);
    bus.req_valid = 1'b0;
    if (bad) begin
      chk("err_pulse", {31'd0, err}, 1);
      chk("err_ready", {31'd0, bus.req_ready}, 1);
      chk("err_busy", {31'd0, busy}, 0);
      chk("err_nostrobe", {30'd0, WrEn, RdEn}, 0);
      @(negedge CLK);
      chk("err_one_cycle", {31'd0, err}, 0);
    end else if (w) begin
      chk("wr_p1_wren", {31'd0, WrEn}, 1);
      chk("wr_p1_rden", {31'd0, RdEn}, 0);
      chk("wr_p1_busy", {31'd0, busy}, 1);
      chk("wr_p1_ready", {31'd0, bus.req_ready}, 0);
      @(negedge CLK);
      chk("wr_p2_wren", {31'd0, WrEn}, 0);
      chk("wr_p2_busy", {31'd0, busy}, 0);
      chk("wr_p2_ready", {31'd0, bus.req_ready}, 1);
    end else begin
      chk("rd_p1_rden", {31'd0, RdEn}, 1);
      chk("rd_p1_ready", {31'd0, bus.req_ready}, 0);
      @(negedge CLK);
      chk("rd_p2_rden", {31'd0, RdEn}, 0);
      chk("rd_p2_valid", {31'd0, bus.rsp_valid}, 0);
      @(negedge CLK);
      chk("rd_p3_valid", {31'd0, bus.rsp_valid}, 1);
      chk("rd_p3_last", {31'd0, bus.rsp_last},
          {31'd0, l == '0});
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || exp_rsp.size() > 0) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_timeout", {31'd0, n >= 400}, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctrl"},
        {25'd0, bus.req_ready, bus.rsp_valid,
         bus.rsp_last, err, busy, WrEn, RdEn}, 0);
    chk({nm, "_data"}, {bus.rsp_data, WrData}, 0);
    chk({nm, "_addr"}, {29'd0, Address}, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    for (int i = 0; i < 8; i++) begin
      rf_mem[i]  = WIDTH'(16'h1000 + i);
      ref_mem[i] = WIDTH'(16'h1000 + i);
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;

    repeat (2) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b1;
    @(negedge CLK);
    chk("post_reset_ready", {31'd0, bus.req_ready}, 1);

    // Directed: write, single read, wrapping burst.
    rr_pct = 100;
    do_cmd(1'b1, 3'd5, 3'd0, 16'hA5A5);
    do_cmd(1'b0, 3'd5, 3'd0, 16'h0000);
    drain();
    do_cmd(1'b0, 3'd5, 3'd3, 16'h0000);
    drain();

    // Backpressure: response held five cycles.
    rr_low = 1'b1;
    do_cmd(1'b0, 3'd6, 3'd3, 16'h0000);
    held = bus.rsp_data;
    repeat (5) begin
      @(negedge CLK);
      chk("hold_valid", {31'd0, bus.rsp_valid}, 1);
      chk("hold_no_rden", {31'd0, RdEn}, 0);
      chk("hold_data", {16'd0, bus.rsp_data},
          {16'd0, held});
    end
    rr_low = 1'b0;
    drain();

    // Out-of-range address rejected.
    do_cmd(1'b1, 3'd7, 3'd0, 16'hDEAD);
    do_cmd(1'b0, 3'd7, 3'd2, 16'h0000);

    // Asynchronous reset in the middle of a burst.
    rr_low = 1'b1;
    do_cmd(1'b0, 3'd2, 3'd3, 16'h0000);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk_zero("midreset");
    exp_wr.delete();
    exp_ra.delete();
    exp_rsp.delete();
    @(negedge CLK);
    RST    = 1'b1;
    rr_low = 1'b0;
    @(negedge CLK);
    chk("midreset_ready", {31'd0, bus.req_ready}, 1);
    chk("midreset_busy", {31'd0, busy}, 0);

    // Randomized commands with random backpressure.
    rr_pct = 70;
    for (int k = 0; k < 40; k++) begin
      do_cmd(1'($urandom_range(0, 1)),
             ADDR_W'($urandom_range(0, 7)),
             ADDR_W'($urandom_range(0, 7)),
             WIDTH'($urandom));
    end
    drain();

    chk("end_wr_q", exp_wr.size(), 0);
    chk("end_ra_q", exp_ra.size(), 0);
    chk("end_rsp_q", exp_rsp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
